// File: rtl/serial_parity_engine_if.sv
// Bus bundle for serial_parity_engine.
//   master: bit source / result consumer (drives data_in, wr_en, odd_sel, abort)
//   slave : the parity engine (drives parity_out, word_valid, busy, err_cnt)
interface serial_parity_engine_if #(
  parameter int LANES = 1,
  parameter int ERR_W = 16
);
  logic [LANES-1:0] data_in;
  logic             wr_en;
  logic             odd_sel;
  logic             abort;
  logic [LANES-1:0] parity_out;
  logic             word_valid;
  logic             busy;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output data_in, wr_en, odd_sel, abort,
    input  parity_out, word_valid, busy, err_cnt
  );

  modport slave (
    input  data_in, wr_en, odd_sel, abort,
    output parity_out, word_valid, busy, err_cnt
  );
endinterface

// File: rtl/serial_parity_engine.sv
// Multi-lane serial parity generator / checker.
// Each lane accumulates one serial bit per wr_en strobe; DATA_BITS bits form a word.
//   GEN   (CHECK_MODE=0): parity_out = required parity bit per lane.
//   CHECK (CHECK_MODE=1): one trailing received parity bit per lane;
//                         parity_out = per-lane mismatch, err_cnt counts bad words.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave modport: data_in/wr_en/odd_sel/abort in,
//        parity_out/word_valid/busy/err_cnt out (all registered except busy)

// Per-lane parity accumulator.
module serial_parity_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,   // abort: drop partial word
  input  logic load_i,  // first bit of a word: seed with odd_sel
  input  logic step_i,  // subsequent data bit
  input  logic odd_i,
  input  logic din_i,
  output logic acc_o
);
  logic acc_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= 1'b0;
    else if (load_i)  acc_q <= odd_i ^ din_i;
    else if (step_i)  acc_q <= acc_q ^ din_i;
  end

  assign acc_o = acc_q;
endmodule

module serial_parity_engine #(
  parameter int DATA_BITS  = 8,
  parameter int LANES      = 1,
  parameter int CHECK_MODE = 0,
  parameter int ERR_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_parity_engine_if.slave  bus
);
  localparam int            CW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] acc;
  logic [LANES-1:0] res_q, res_d;
  logic             wv_q, wv_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic take, load, step, fin, busy_w;

  // Abort outranks the strobe: an aborted bit is never accepted.
  assign take = bus.wr_en & ~bus.abort;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wv_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else if (bus.wr_en) begin
      case (state_q)
        S_IDLE:  state_d = S_DATA;
        S_DATA:  if (cnt_q == LAST) state_d = (CHECK_MODE != 0) ? S_PAR : S_IDLE;
        S_PAR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- output / control decode ----
  always_comb begin
    busy_w = (state_q != S_IDLE);
    load   = take && (state_q == S_IDLE);
    step   = take && (state_q == S_DATA);
    // Final accepted bit: last data bit in GEN, the received parity bit in CHECK.
    fin    = take && (((state_q == S_DATA) && (cnt_q == LAST) && (CHECK_MODE == 0)) ||
                      (state_q == S_PAR));
  end

  // ---- datapath next-state ----
  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    wv_d  = 1'b0;
    err_d = err_q;
    if (bus.abort)  cnt_d = '0;
    else if (load)  cnt_d = CW'(1);
    else if (step)  cnt_d = cnt_q + 1'b1;
    if (fin) begin
      // GEN: acc ^ last data bit = parity; CHECK: acc ^ received bit = mismatch.
      res_d = acc ^ bus.data_in;
      wv_d  = 1'b1;
      cnt_d = '0;
      if ((CHECK_MODE != 0) && (|res_d) && !(&err_q)) err_d = err_q + 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serial_parity_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (bus.abort),
      .load_i (load),
      .step_i (step),
      .odd_i  (bus.odd_sel),
      .din_i  (bus.data_in[l]),
      .acc_o  (acc[l])
    );
  end

  assign bus.parity_out = res_q;
  assign bus.word_valid = wv_q;
  assign bus.busy       = busy_w;
  assign bus.err_cnt    = err_q;
endmodule
